// File: rtl/ct_ifu_icache_tag_ctrl_if.sv
// Request, response and tag-SRAM signal bundle of the IFU icache tag controller.
// The controller connects through the slave modport; requesters and the SRAM model use master.
interface ct_ifu_icache_tag_ctrl_if #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 28,
    parameter int ROW_W = 59
);
    logic             inv_req;
    logic             inv_done;
    logic             refill_vld;
    logic [IDX_W-1:0] refill_idx;
    logic [TAG_W-1:0] refill_tag;
    logic             refill_way;
    logic             refill_grant;
    logic             lkup_vld;
    logic [IDX_W-1:0] lkup_idx;
    logic [TAG_W-1:0] lkup_ptag;
    logic             lkup_grant;
    logic             rsp_vld;
    logic             rsp_hit;
    logic             rsp_hit_way;
    logic             rsp_victim;
    logic             busy;
    logic             tag_cen_b;
    logic             tag_gwen_b;
    logic [ROW_W-1:0] tag_wen_b;
    logic [ROW_W-1:0] tag_din;
    logic [IDX_W-1:0] tag_idx;
    logic [ROW_W-1:0] tag_dout;

    modport slave (
        input  inv_req, refill_vld, refill_idx, refill_tag, refill_way,
        input  lkup_vld, lkup_idx, lkup_ptag, tag_dout,
        output inv_done, refill_grant, lkup_grant,
        output rsp_vld, rsp_hit, rsp_hit_way, rsp_victim, busy,
        output tag_cen_b, tag_gwen_b, tag_wen_b, tag_din, tag_idx
    );

    modport master (
        output inv_req, refill_vld, refill_idx, refill_tag, refill_way,
        output lkup_vld, lkup_idx, lkup_ptag, tag_dout,
        input  inv_done, refill_grant, lkup_grant,
        input  rsp_vld, rsp_hit, rsp_hit_way, rsp_victim, busy,
        input  tag_cen_b, tag_gwen_b, tag_wen_b, tag_din, tag_idx
    );
endinterface

// File: rtl/ct_ifu_icache_tag_ctrl.sv
// IFU icache tag-array access controller: arbitrates invalidate-all sweeps, refill
// tag writes and fetch lookups onto the single-port tag SRAM and returns lookup results.
module ct_ifu_icache_tag_ctrl #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 28,
    parameter int ROW_W = 59
) (
    input logic                      forever_cpuclk,
    input logic                      cpurst,
    ct_ifu_icache_tag_ctrl_if.slave  bus
);

    localparam int FLD_W = TAG_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_INV  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q;
    logic             rd_vld_q;
    logic [TAG_W-1:0] ptag_q;
    logic [ROW_W-1:0] din_q;
    logic [IDX_W-1:0] idx_q;

    logic             inv_start;
    logic             refill_gnt_c;
    logic             lkup_gnt_c;
    logic             busy_c;
    logic             cen_b_c;
    logic             gwen_b_c;
    logic [ROW_W-1:0] wen_b_c;
    logic [ROW_W-1:0] din_c;
    logic [IDX_W-1:0] idx_c;
    logic             hit0;
    logic             hit1;

    // The inv_done cycle cannot restart a sweep: the requester is still dropping inv_req.
    assign inv_start = bus.inv_req & ~done_q;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (inv_start) begin
                    state_d = S_INV;
                end
            end
            S_INV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {IDX_W{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c       = 1'b0;
        refill_gnt_c = 1'b0;
        lkup_gnt_c   = 1'b0;
        cen_b_c      = 1'b1;
        gwen_b_c     = 1'b1;
        wen_b_c      = {ROW_W{1'b1}};
        din_c        = din_q;
        idx_c        = idx_q;
        case (state_q)
            S_INV: begin
                busy_c   = 1'b1;
                cen_b_c  = 1'b0;
                gwen_b_c = 1'b0;
                wen_b_c  = '0;
                din_c    = '0;
                idx_c    = cnt_q;
            end
            default: begin
                if (!inv_start && bus.refill_vld) begin
                    refill_gnt_c = 1'b1;
                    cen_b_c      = 1'b0;
                    gwen_b_c     = 1'b0;
                    idx_c        = bus.refill_idx;
                    din_c        = '0;
                    if (bus.refill_way) begin
                        wen_b_c[2*FLD_W-1:FLD_W] = '0;
                        din_c[2*FLD_W-1:FLD_W]   = {1'b1, bus.refill_tag};
                    end else begin
                        wen_b_c[FLD_W-1:0] = '0;
                        din_c[FLD_W-1:0]   = {1'b1, bus.refill_tag};
                    end
                    // Replacement pointer flips to the way not just filled.
                    wen_b_c[ROW_W-1] = 1'b0;
                    din_c[ROW_W-1]   = ~bus.refill_way;
                end else if (!inv_start && bus.lkup_vld) begin
                    lkup_gnt_c = 1'b1;
                    cen_b_c    = 1'b0;
                    idx_c      = bus.lkup_idx;
                end
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            cnt_q    <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            din_q    <= '0;
            idx_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            done_q   <= (state_q == S_INV) && (cnt_q == {IDX_W{1'b1}});
            rd_vld_q <= lkup_gnt_c;
            din_q    <= din_c;
            idx_q    <= idx_c;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (lkup_gnt_c) begin
            ptag_q <= bus.lkup_ptag;
        end
    end

    assign hit0 = bus.tag_dout[FLD_W-1]   & (bus.tag_dout[TAG_W-1:0] == ptag_q);
    assign hit1 = bus.tag_dout[2*FLD_W-1] & (bus.tag_dout[2*FLD_W-2:FLD_W] == ptag_q);

    assign bus.inv_done     = done_q;
    assign bus.busy         = busy_c;
    assign bus.refill_grant = refill_gnt_c;
    assign bus.lkup_grant   = lkup_gnt_c;
    assign bus.rsp_vld      = rd_vld_q;
    assign bus.rsp_hit      = rd_vld_q & (hit0 | hit1);
    // A double hit is a software error; way 0 wins.
    assign bus.rsp_hit_way  = rd_vld_q & hit1 & ~hit0;
    assign bus.rsp_victim   = rd_vld_q & bus.tag_dout[ROW_W-1];
    assign bus.tag_cen_b    = cen_b_c;
    assign bus.tag_gwen_b   = gwen_b_c;
    assign bus.tag_wen_b    = wen_b_c;
    assign bus.tag_din      = din_c;
    assign bus.tag_idx      = idx_c;

endmodule

// File: doc/ct_ifu_icache_tag_ctrl.md
# ct_ifu_icache_tag_ctrl

Access controller for the IFU instruction-cache tag array, a 256-set, 2-way, 59-bit-per-row single-port SRAM with active-low chip, global-write and per-bit write enables. It sits directly upstream of the tag SRAM. It arbitrates three sources onto the single SRAM port: invalidate-all sweeps, refill tag writes and fetch lookups. It returns a per-lookup hit/way/victim result one cycle after each granted read.

## Interface

Parameters:
- IDX_W, 8, set index width (256 sets)
- TAG_W, 28, physical tag width per way
- ROW_W, 59, SRAM row width; row layout {fifo[58], vld1[57], tag1[56:29], vld0[28], tag0[27:0]}

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset; asynchronous, active-high
- inv_req  in  1  invalidate-all request; level, held until inv_done
- inv_done  out  1  one-cycle pulse after the last set is cleared
- refill_vld  in  1  refill tag write request
- refill_idx  in  IDX_W  refill set
- refill_tag  in  TAG_W  refill tag
- refill_way  in  1  way to write
- refill_grant  out  1  refill accepted this cycle
- lkup_vld  in  1  lookup request
- lkup_idx  in  IDX_W  lookup set
- lkup_ptag  in  TAG_W  physical tag to compare
- lkup_grant  out  1  lookup accepted this cycle
- rsp_vld  out  1  lookup result valid
- rsp_hit  out  1  either way valid and tag-equal
- rsp_hit_way  out  1  hitting way (0 if no hit)
- rsp_victim  out  1  fifo bit of the set (next replacement way)
- busy  out  1  invalidate sweep in progress
- tag_cen_b  out  1  SRAM chip enable, active-low
- tag_gwen_b  out  1  SRAM global write enable, active-low
- tag_wen_b  out  ROW_W  SRAM bit write enables, active-low
- tag_din  out  ROW_W  SRAM write data
- tag_idx  out  IDX_W  SRAM address
- tag_dout  in  ROW_W  SRAM read data, valid the cycle after a read

## Operation

- FSM states are IDLE and INV. Reset enters IDLE with the sweep counter at 0.
- IDLE to INV: inv_req=1. Sweep counter cnt is 8 bits.
- INV: each cycle drives a write at index cnt, with cen_b=0, gwen_b=0, wen_b all 0 and din all 0, then increments cnt.
- INV exit: on the cycle cnt==255 is written, inv_done pulses the following cycle, the FSM returns to IDLE and cnt wraps to 0.
- A new inv_req seen in IDLE after inv_done starts a new sweep. The requester must drop inv_req on inv_done.
- Priority in IDLE, highest first: inv_req, then refill, then lookup. refill_grant and lkup_grant are never both 1. In INV both grants are 0 and busy=1.
- Refill write: cen_b=0, gwen_b=0, idx=refill_idx. wen_b is 0 on the selected way's 29-bit field and on bit 58; all other bits are 1.
- Refill data: the selected field is {1'b1, refill_tag} and bit 58 is ~refill_way. Only those bits are written; the other way is preserved.
- Lookup read: cen_b=0, gwen_b=1, wen_b all 1, idx=lkup_idx. lkup_ptag is registered on grant.
- Next cycle, rsp_vld=1. hit0 = vld0 & (tag0==ptag_q) and hit1 = vld1 & (tag1==ptag_q).
- rsp_hit = hit0|hit1 and rsp_hit_way = hit1 & ~hit0. rsp_victim = tag_dout[58].
- With both ways hitting (software error), the result reports way 0.
- SRAM idle cycles: cen_b=1, gwen_b=1, wen_b all 1. tag_din and tag_idx are don't-care but must be driven stable (hold last value).
- Reset mid-sweep aborts the sweep: FSM returns to IDLE, cnt is cleared, and inv_done is not pulsed.

## Timing

- Reset values: inv_done=0, refill_grant=0, lkup_grant=0, rsp_vld=0, rsp_hit=0, rsp_hit_way=0, rsp_victim=0, busy=0, tag_cen_b=1, tag_gwen_b=1, tag_wen_b all 1, tag_din=0, tag_idx=0.
- Grants are combinational from the request inputs and FSM state in the same cycle. SRAM controls are combinational from the grant/state selection.
- Lookup latency is 1 cycle: grant in cycle N gives rsp_* in N+1. Results are combinational from tag_dout and ptag_q, and are valid for that cycle only.
- Back-to-back lookups get one result per cycle.
- A refill in cycle N followed by a lookup of the same set in N+1 must observe the new row.
- Invalidate-all takes 256 write cycles. inv_done arrives 257 cycles after the entering cycle.
- A refill or lookup that is not granted must be held by its requester. Requests are not queued.

## Test plan

- Reset then idle: all outputs at their reset values; SRAM cen_b=1 for 10 cycles.
- Refill idx=0x12, tag=0xABCDEF1, way=1; then lookup idx=0x12, ptag=0xABCDEF1. Required: the refill writes row bits[57:29]={1,0xABCDEF1}, bit58=0, wen_b[28:0]=all 1. Next-cycle result: rsp_hit=1, rsp_hit_way=1, rsp_victim=0.
- Lookup of idx=0x12 with ptag=0x0000001 -> rsp_vld=1, rsp_hit=0, rsp_hit_way=0.
- Simultaneous refill_vld and lkup_vld -> refill_grant=1 and lkup_grant=0. The lookup is granted the next cycle and sees the refilled row.
- Invalidate with inv_req, while refill_vld and lkup_vld are held:
  - tag_idx steps 0 through 255 with writes of all-zero data.
  - busy=1 and both grants are 0 for 256 cycles; inv_done pulses exactly once.
  - A following lookup of idx=0x12 returns rsp_hit=0.
- Assert cpurst at cnt=100 during a sweep -> outputs return to reset values immediately and no inv_done pulse. A new inv_req restarts the sweep at idx 0.
